// File: rtl/sync_sim_if.sv
// sync_sim bus: run control in, wheel waveforms out.
// master drives enable/period, slave is the simulator.
interface sync_sim_if #(
  parameter int PERIOD_W = 24,
  parameter int TOOTH_W  = 8
);
  logic                enable;
  logic [PERIOD_W-1:0] period;
  logic                crank;
  logic                cam;
  logic                sync;
  logic [TOOTH_W-1:0]  tooth;

  modport master (
    output enable, period,
    input  crank, cam, sync, tooth
  );

  modport slave (
    input  enable, period,
    output crank, cam, sync, tooth
  );
endinterface

// File: rtl/sync_sim.sv
// sync_sim: N-minus-M crank/cam trigger-wheel simulator.
// Optional cam output enabled by defining SYNC_SIM_CAM_EN.
module sync_sim #(
  parameter int TEETH     = 60,
  parameter int MISSING   = 2,
  parameter int PERIOD_W  = 24,
  parameter int TOOTH_W   = 8,
  parameter int CAM_TOOTH = 10,
  parameter int CAM_WIDTH = 2
) (
  input logic       clock,
  input logic       reset_n,
  sync_sim_if.slave bus
);

  localparam int SLOTS  = 2 * TEETH;
  localparam int SLOT_W = $clog2(SLOTS);
  localparam int REAL   = TEETH - MISSING;

  localparam logic [SLOT_W-1:0] LAST =
    SLOT_W'(SLOTS - 1);
  localparam logic [SLOT_W-1:0] LAST_PULSE =
    SLOT_W'(2 * REAL - 2);
  localparam logic [SLOT_W-1:0] GAP =
    SLOT_W'(2 * REAL);
  localparam logic [PERIOD_W-1:0] P_MIN =
    PERIOD_W'(2);

  if (TEETH < 3 || MISSING < 1 ||
      MISSING > TEETH - 2 ||
      (2 ** TOOTH_W) < TEETH ||
      PERIOD_W < 2 || CAM_WIDTH < 1 ||
      CAM_TOOTH + CAM_WIDTH > TEETH)
  begin : g_bad_params
    $error("sync_sim: bad parameters");
  end

  logic                run_q, run_d;
  logic [PERIOD_W-1:0] psc_q, psc_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                wrap_q, wrap_d;
  logic                crank_q, crank_d;
  logic                sync_q, sync_d;
  logic [TOOTH_W-1:0]  tooth_q, tooth_d;

  logic                live;
  logic                slot_end;
  logic [PERIOD_W-1:0] per_in;

  assign live     = bus.enable && run_q;
  assign slot_end = psc_q == per_q - PERIOD_W'(1);
  assign per_in   = (bus.period < P_MIN) ?
                    P_MIN : bus.period;

  // Prescaler, slot counter and period latch.
  always_comb begin
    run_d  = run_q;
    psc_d  = psc_q;
    per_d  = per_q;
    slot_d = slot_q;
    wrap_d = 1'b0;
    if (!bus.enable) begin
      run_d  = 1'b0;
      psc_d  = '0;
      slot_d = '0;
    end else if (!run_q) begin
      run_d  = 1'b1;
      psc_d  = '0;
      slot_d = '0;
      per_d  = per_in;
    end else if (slot_end) begin
      psc_d = '0;
      if (slot_q == LAST) begin
        slot_d = '0;
        per_d  = per_in;
        wrap_d = 1'b1;
      end else begin
        slot_d = slot_q + SLOT_W'(1);
      end
    end else begin
      psc_d = psc_q + PERIOD_W'(1);
    end
  end

  // Registered outputs lag the slot state by one clock.
  always_comb begin
    crank_d = 1'b0;
    sync_d  = 1'b0;
    tooth_d = '0;
    if (live) begin
      crank_d = (slot_q < LAST_PULSE) ?
                !slot_q[0] : (slot_q < GAP);
      sync_d  = wrap_q;
      tooth_d = TOOTH_W'(slot_q >> 1);
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_q   <= 1'b0;
      psc_q   <= '0;
      per_q   <= P_MIN;
      slot_q  <= '0;
      wrap_q  <= 1'b0;
      crank_q <= 1'b0;
      sync_q  <= 1'b0;
      tooth_q <= '0;
    end else begin
      run_q   <= run_d;
      psc_q   <= psc_d;
      per_q   <= per_d;
      slot_q  <= slot_d;
      wrap_q  <= wrap_d;
      crank_q <= crank_d;
      sync_q  <= sync_d;
      tooth_q <= tooth_d;
    end
  end

  assign bus.crank = crank_q;
  assign bus.sync  = sync_q;
  assign bus.tooth = tooth_q;

`ifdef SYNC_SIM_CAM_EN
  localparam logic [SLOT_W-1:0] CAM_LO =
    SLOT_W'(2 * CAM_TOOTH);
  localparam logic [SLOT_W-1:0] CAM_HI =
    SLOT_W'(2 * (CAM_TOOTH + CAM_WIDTH) - 1);

  logic phase_q, phase_d;
  logic cam_q, cam_d;

  // Phase flips per revolution so cam fires every 720 degrees.
  always_comb begin
    phase_d = phase_q;
    if (!bus.enable) begin
      phase_d = 1'b0;
    end else if (wrap_d) begin
      phase_d = !phase_q;
    end
    cam_d = live && phase_q &&
            slot_q >= CAM_LO &&
            slot_q <= CAM_HI;
  end

  // Cam phase and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 1'b0;
      cam_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cam_q   <= cam_d;
    end
  end

  assign bus.cam = cam_q;
`else
  assign bus.cam = 1'b0;
`endif

endmodule

// File: tb/tb_sync_sim.sv
// tb_sync_sim: random and directed checks of sync_sim
// against a time-in-revolution reference model.
module tb_sync_sim;

  localparam int T  = 6;
  localparam int M  = 1;
  localparam int R  = T - M;
  localparam int CT = 1;
  localparam int CW = 2;
  localparam int PW = 24;
  localparam int TW = 8;
`ifdef SYNC_SIM_CAM_EN
  localparam bit CAM_ON = 1'b1;
`else
  localparam bit CAM_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sync_sim_if #(.PERIOD_W(PW), .TOOTH_W(TW)) sif ();
  sync_sim_if #(.PERIOD_W(24), .TOOTH_W(8)) bif ();

  sync_sim #(
    .TEETH(T), .MISSING(M), .PERIOD_W(PW),
    .TOOTH_W(TW), .CAM_TOOTH(CT), .CAM_WIDTH(CW)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .bus(sif.slave)
  );

  sync_sim u_big (
    .clock(clock), .reset_n(reset_n), .bus(bif.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
    end
  endtask

  function automatic int clampp(input int p);
    return (p < 2) ? 2 : p;
  endfunction

  // Reference model: position in revolution, in clocks.
  bit m_run = 1'b0;
  int m_t = 0, m_p = 2, m_rev = 0;
  int m_s, m_k;
  logic e_crank = 1'b0, e_cam = 1'b0, e_sync = 1'b0;
  int e_tooth = 0;

  always @(posedge clock) begin
    if (!reset_n) begin
      m_run = 1'b0; m_t = 0; m_rev = 0; m_p = 2;
      e_crank = 1'b0; e_cam = 1'b0;
      e_sync = 1'b0; e_tooth = 0;
    end else begin
      if (sif.enable && m_run) begin
        m_s = m_t / m_p;
        m_k = m_s / 2;
        e_crank = (m_k < R - 1) ? (m_s % 2 == 0)
                                : (m_k == R - 1);
        e_tooth = m_k;
        e_sync  = (m_t == 0) && (m_rev > 0);
        e_cam   = CAM_ON && (m_rev % 2 == 1) &&
                  m_s >= 2 * CT && m_s < 2 * (CT + CW);
      end else begin
        e_crank = 1'b0; e_cam = 1'b0;
        e_sync = 1'b0; e_tooth = 0;
      end
      if (!sif.enable) begin
        m_run = 1'b0;
      end else if (!m_run) begin
        m_run = 1'b1; m_t = 0; m_rev = 0;
        m_p = clampp(int'(sif.period));
      end else begin
        m_t++;
        if (m_t == 2 * T * m_p) begin
          m_t = 0; m_rev++;
          m_p = clampp(int'(sif.period));
        end
      end
    end
  end

  // Every-cycle compare of the small wheel against the model.
  always @(negedge clock) begin
    if (!reset_n) begin
      check("crank", sif.crank, 0);
      check("cam", sif.cam, 0);
      check("sync", sif.sync, 0);
      check("tooth", sif.tooth, 0);
    end else begin
      check("crank", sif.crank, e_crank);
      check("cam", sif.cam, e_cam);
      check("sync", sif.sync, e_sync);
      check("tooth", sif.tooth, e_tooth);
    end
  end

  task automatic wait_sync(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!sif.sync && n < 400);
    if (!sif.sync) begin
      check("sync_timeout", n, 0);
      n = -1;
    end
  endtask

  task automatic wait_sync_big(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bif.sync && n < 2000);
    if (!bif.sync) begin
      check("big_sync_timeout", n, 0);
      n = -1;
    end
  endtask

  logic [11:0] mask;
  int n, cnt, rises, run, maxh, maxl;
  logic c, prev;

  initial begin
    mask = 12'h355;
    sif.enable = 1'b0; sif.period = PW'(3);
    bif.enable = 1'b0; bif.period = 24'd5;
    repeat (3) @(negedge clock);
    check("rst_crank", sif.crank, 0);
    check("rst_tooth", sif.tooth, 0);
    check("rst_sync", sif.sync, 0);
    reset_n = 1'b1;
    @(negedge clock);
    sif.enable = 1'b1;
    bif.enable = 1'b1;

    // Default 60-2 wheel at period 5.
    wait_sync_big(n);
    rises = 0; run = 0; maxh = 0; maxl = 0;
    prev = 1'b0;
    for (int i = 0; i < 600; i++) begin
      c = bif.crank;
      if (c && !prev) rises++;
      if (i > 0 && c != prev) begin
        if (prev) maxh = (run > maxh) ? run : maxh;
        else      maxl = (run > maxl) ? run : maxl;
        run = 0;
      end
      run++;
      prev = c;
      @(negedge clock);
    end
    if (prev) maxh = (run > maxh) ? run : maxh;
    else      maxl = (run > maxl) ? run : maxl;
    check("big_rises", rises, 58);
    check("big_last_high", maxh, 10);
    check("big_gap_low", maxl, 20);
    check("big_rev_600", bif.sync, 1);

    // Small wheel geometry at period 3.
    wait_sync(n);
    for (int i = 0; i < 36; i++) begin
      check("geo_crank", sif.crank, mask[i / 3]);
      check("geo_tooth", sif.tooth, i / 6);
      if (i > 0) check("geo_nosync", sif.sync, 0);
      @(negedge clock);
    end
    check("geo_rev_36", sif.sync, 1);
    cnt = 0;
    for (int i = 0; i < 72; i++) begin
      if (sif.cam) cnt++;
      @(negedge clock);
    end
    check("cam_clocks_72", cnt, CAM_ON ? 12 : 0);

    // Speed change at slot 4, then period 0.
    wait_sync(n);
    repeat (12) @(negedge clock);
    sif.period = PW'(7);
    wait_sync(n); check("spd_old", n, 24);
    wait_sync(n); check("spd_new", n, 84);
    sif.period = PW'(0);
    wait_sync(n); check("spd_hold", n, 84);
    wait_sync(n); check("spd_zero", n, 24);
    sif.period = PW'(3);
    wait_sync(n); check("spd_back", n, 24);
    wait_sync(n); check("spd_three", n, 36);

    // Abort at slot 5, then restart.
    repeat (15) @(negedge clock);
    check("pre_abort_tooth", sif.tooth, 2);
    sif.enable = 1'b0;
    @(negedge clock);
    check("abort_crank", sif.crank, 0);
    check("abort_tooth", sif.tooth, 0);
    check("abort_sync", sif.sync, 0);
    repeat (3) @(negedge clock);
    sif.enable = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 36; i++) begin
      @(negedge clock);
      if (i == 2) check("restart_crank", sif.crank, 1);
      if (sif.sync) cnt++;
    end
    check("restart_nosync", cnt, 0);
    wait_sync(n); check("restart_first", n, 2);

    // Asynchronous reset in the middle of slot 2.
    repeat (6) @(negedge clock);
    check("pre_rst_crank", sif.crank, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_crank", sif.crank, 0);
    check("async_rst_tooth", sif.tooth, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Randomised enable, period and reset traffic.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if (!reset_n) reset_n = 1'b1;
      if ($urandom % 150 == 0)
        sif.enable = !sif.enable;
      if ($urandom % 60 == 0)
        sif.period = PW'($urandom_range(0, 6));
      if ($urandom % 1500 == 0)
        #2 reset_n = 1'b0;
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_sim.md
# sync_sim

Parametrised crank/cam trigger-wheel simulator for bench and HIL testing of the sync decoder. It generates an N-minus-M toothed crank waveform with a run-time programmable half-tooth period (engine speed), a one-cycle revolution marker and a tooth index. An optional cam output pulses once every two crank revolutions. It is the successor to the fixed 60-2 faker: wheel geometry is set by parameters, speed is an input, and start/stop is controlled by `enable`.

## Interface
- `TEETH`, 60, physical tooth positions per crank revolution, including the missing ones; minimum 3.
- `MISSING`, 2, missing teeth in the gap; 1 ≤ MISSING ≤ TEETH-2.
- `PERIOD_W`, 24, width of the `period` input.
- `TOOTH_W`, 8, width of `tooth`; must satisfy 2^TOOTH_W ≥ TEETH.
- `CAM_TOOTH`, 10, tooth position at which the cam pulse starts.
- `CAM_WIDTH`, 2, cam pulse length in tooth positions.

Ports:
- `clock  in  1` — system clock; all logic on its rising edge.
- `reset_n  in  1` — asynchronous, active-low reset.
- `enable  in  1` — run when high; when low, hold idle.
- `period  in  PERIOD_W` — clock cycles per half-tooth slot.
- `crank  out  1` — simulated VR/crank signal.
- `cam  out  1` — simulated cam signal.
- `sync  out  1` — one-cycle pulse at the start of each revolution.
- `tooth  out  TOOTH_W` — current tooth position, 0..TEETH-1 (slot >> 1).

## Operation
- Each revolution is divided into 2*TEETH half-tooth slots, indexed 0..2*TEETH-1 by `slot`.
- A prescaler counts 0..P-1, where P is the latched period. `slot` advances when the prescaler reaches P-1, then the prescaler returns to 0.
- Period latch:
  - `period` is latched into P on the `enable` rising edge and at every slot wrap from 2*TEETH-1 to 0.
  - A new speed therefore takes effect only at a revolution boundary.
  - A latched value below 2 is clamped to 2.
- Crank pattern, with R = TEETH-MISSING real teeth:
  - For tooth k < R-1, `crank` is high in slot 2k and low in slot 2k+1.
  - The last real tooth (k = R-1) is high for both slots 2R-2 and 2R-1.
  - Slots 2R through 2*TEETH-1 are low (the gap).
  - Defaults give 58 pulses per revolution; the last pulse is widened and followed by a 4-slot low gap.
- `sync` goes high for exactly one clock when `slot` becomes 0 after a wrap. It does not fire on the initial start from idle.
- `enable` low:
  - Prescaler, slot and cam phase are forced to 0.
  - `crank`, `cam` and `sync` are 0; `tooth` is 0.
  - Deasserting mid-revolution aborts immediately on the next clock.
- `enable` rising: slot 0 starts on the next clock with `crank` high.
- Reset values: every output is 0, slot = 0, prescaler = 0, P = 2, cam phase = 0.

## Timing
- All outputs are registered. `crank`, `tooth` and `cam` change one clock after the internal slot transition.
- A full revolution takes 2*TEETH*P clocks. Each slot lasts exactly P clocks, with no jitter.
- A `period` change mid-revolution is ignored until the next wrap; the wrap cycle uses the new value.
- `reset_n` assertion mid-revolution clears everything asynchronously. After release, the block idles until `enable` is sampled high.

## Configuration
- Macro: `SYNC_SIM_CAM_EN`.
- Defined:
  - A cam phase flop toggles at every slot wrap.
  - `cam` is high for slots 2*CAM_TOOTH through 2*(CAM_TOOTH+CAM_WIDTH)-1 only while the phase is 1, i.e. once per 720°.
- Undefined:
  - The phase flop and cam compare logic are not compiled.
  - `cam` is tied to 0; the port remains present.

## Test plan
- Geometry: TEETH=6, MISSING=1, period=3, enable high.
  - `crank` is high in slots 0, 2, 4, 6, 8 and 9, and low elsewhere.
  - Each slot lasts 3 clocks; a revolution is 36 clocks.
  - `sync` pulses once every 36 clocks.
  - `tooth` steps 0..5.
- Defaults, period=5: 58 rising edges of `crank` per 600 clocks; the last high pulse is 10 clocks long and is followed by 20 clocks low.
- Speed change: TEETH=6, MISSING=1, period switched from 3 to 7 at slot 4.
  - Slots continue at 3 clocks until the wrap.
  - The next revolution runs at 7 clocks per slot.
  - period=0 behaves as period=2.
- Abort and reset:
  - `enable` dropped at slot 5: all outputs are 0 on the next clock.
  - Re-enable restarts at slot 0 with no `sync` pulse.
  - `reset_n` low mid-slot clears outputs with no clock edge.
- Cam with `SYNC_SIM_CAM_EN`, TEETH=6, MISSING=1, CAM_TOOTH=1, CAM_WIDTH=2, period=3:
  - `cam` is high for slots 2–5 (12 clocks) in every second revolution only.
  - Without the macro, `cam` stays 0 throughout.
